// File: rtl/id_scoreboard.sv
// Decode-stage register scoreboard and hazard unit.
// Tracks pending writes; drives stall and per-source bypass selects.
module id_scoreboard #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_SRC        = 3,
  parameter int LAT_WIDTH      = 3,
  parameter int FWD_DEPTH      = 2,
  parameter int MAX_VAR        = 2,
  parameter int ZERO_HARDWIRED = 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                issue_valid_i,
  input  logic                                issue_wr_i,
  input  logic [REG_ADDR_WIDTH-1:0]           issue_rd_i,
  input  logic [LAT_WIDTH-1:0]                issue_lat_i,
  input  logic [NUM_SRC-1:0]                  src_used_i,
  input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]   src_addr_i,
  input  logic                                flush_i,
  input  logic                                cpl_valid_i,
  input  logic [REG_ADDR_WIDTH-1:0]           cpl_rd_i,
  output logic                                stall_o,
  output logic [NUM_SRC*LAT_WIDTH-1:0]        fwd_sel_o,
  output logic [$clog2(MAX_VAR+1)-1:0]        var_busy_o,
  output logic [2**REG_ADDR_WIDTH-1:0]        pending_o,
  output logic                                err_o
);

  localparam int AW  = REG_ADDR_WIDTH;
  localparam int LW  = LAT_WIDTH;
  localparam int NR  = 2**REG_ADDR_WIDTH;
  localparam int VBW = $clog2(MAX_VAR+1);
  localparam bit ZH  = (ZERO_HARDWIRED != 0);
  localparam logic [LW-1:0]  FWD  = LW'(FWD_DEPTH);
  localparam logic [VBW-1:0] VMAX = VBW'(MAX_VAR);

  logic [NR-1:0]  pend_q, pend_d;
  logic [NR-1:0]  var_q, var_d;
  logic [LW-1:0]  cnt_q [NR];
  logic [LW-1:0]  cnt_d [NR];
  logic [VBW-1:0] busy_q, busy_d;
  logic           err_q, err_d;

  logic [NUM_SRC-1:0] nrdy;
  logic is_var, lat_bad, waw, vfull;
  logic accept, alloc, cpl_ok;

  // lat of all-ones is illegal and falls back to variable tracking
  assign lat_bad = (issue_lat_i == '1);
  assign is_var  = (issue_lat_i == '0) | lat_bad;

  // Per-source readiness and bypass select
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [AW-1:0] a;
    logic          live;
    logic          hit;
    assign a    = src_addr_i[g*AW +: AW];
    assign live = src_used_i[g] & pend_q[a] & ~(ZH && (a == '0));
    assign hit  = cpl_valid_i & (cpl_rd_i == a) & var_q[a];
    assign nrdy[g] = live & (var_q[a] ? ~hit : (cnt_q[a] > FWD));
    assign fwd_sel_o[g*LW +: LW] =
      !live    ? '0 :
      var_q[a] ? (hit ? '1 : '0) :
                 cnt_q[a];
  end

  assign waw = issue_wr_i & pend_q[issue_rd_i] &
               (var_q[issue_rd_i] | is_var |
                (cnt_q[issue_rd_i] > issue_lat_i));
  assign vfull = issue_wr_i & is_var & (busy_q == VMAX);

  assign stall_o = issue_valid_i & ((|nrdy) | waw | vfull);
  assign accept  = issue_valid_i & ~stall_o & ~flush_i;
  assign alloc   = accept & issue_wr_i &
                   ~(ZH && (issue_rd_i == '0));
  assign cpl_ok  = cpl_valid_i & pend_q[cpl_rd_i] & var_q[cpl_rd_i];

  // Countdown, completion, then allocation (allocation wins)
  always_comb begin
    pend_d = pend_q;
    var_d  = var_q;
    cnt_d  = cnt_q;
    for (int r = 0; r < NR; r++) begin
      if (pend_q[r] && !var_q[r]) begin
        if (cnt_q[r] <= LW'(1)) begin
          pend_d[r] = 1'b0;
          cnt_d[r]  = '0;
        end else begin
          cnt_d[r] = cnt_q[r] - LW'(1);
        end
      end
    end
    if (cpl_ok) begin
      pend_d[cpl_rd_i] = 1'b0;
      var_d[cpl_rd_i]  = 1'b0;
    end
    if (alloc) begin
      pend_d[issue_rd_i] = 1'b1;
      var_d[issue_rd_i]  = is_var;
      cnt_d[issue_rd_i]  = is_var ? '0 : issue_lat_i;
    end
    busy_d = busy_q + VBW'(alloc & is_var) - VBW'(cpl_ok);
    err_d  = err_q | (cpl_valid_i & ~cpl_ok) |
             (accept & issue_wr_i & lat_bad);
  end

  // Scoreboard state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      var_q  <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
      for (int r = 0; r < NR; r++) cnt_q[r] <= '0;
    end else begin
      pend_q <= pend_d;
      var_q  <= var_d;
      busy_q <= busy_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign var_busy_o = busy_q;
  assign pending_o  = pend_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard.
// Expected values are queued with the stimulus and popped on check.
module tb_id_scoreboard;
  localparam int AW = 5;
  localparam int NS = 3;
  localparam int LW = 3;
  localparam int NR = 32;
  localparam int VBW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic issue_valid_i, issue_wr_i;
  logic [AW-1:0] issue_rd_i;
  logic [LW-1:0] issue_lat_i;
  logic [NS-1:0] src_used_i;
  logic [NS*AW-1:0] src_addr_i;
  logic flush_i, cpl_valid_i;
  logic [AW-1:0] cpl_rd_i;
  logic stall_o;
  logic [NS*LW-1:0] fwd_sel_o;
  logic [VBW-1:0] var_busy_o;
  logic [NR-1:0] pending_o;
  logic err_o;

  id_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid_i(issue_valid_i), .issue_wr_i(issue_wr_i),
    .issue_rd_i(issue_rd_i), .issue_lat_i(issue_lat_i),
    .src_used_i(src_used_i), .src_addr_i(src_addr_i),
    .flush_i(flush_i), .cpl_valid_i(cpl_valid_i),
    .cpl_rd_i(cpl_rd_i), .stall_o(stall_o),
    .fwd_sel_o(fwd_sel_o), .var_busy_o(var_busy_o),
    .pending_o(pending_o), .err_o(err_o)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic exp(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, e);
    end
  endtask

  function automatic logic [LW-1:0] sel(input int i);
    return fwd_sel_o[i*LW +: LW];
  endfunction

  task automatic idle();
    issue_valid_i = 0; issue_wr_i = 0;
    issue_rd_i = '0; issue_lat_i = '0;
    src_used_i = '0; src_addr_i = '0;
    flush_i = 0; cpl_valid_i = 0; cpl_rd_i = '0;
  endtask

  task automatic iss(input int rd, input int lat);
    issue_valid_i = 1; issue_wr_i = 1;
    issue_rd_i = rd[AW-1:0]; issue_lat_i = lat[LW-1:0];
  endtask

  task automatic use_src(input int i, input int a);
    issue_valid_i = 1; issue_wr_i = 0;
    src_used_i[i] = 1'b1;
    src_addr_i[i*AW +: AW] = a[AW-1:0];
  endtask

  task automatic cpl(input int rd);
    cpl_valid_i = 1; cpl_rd_i = rd[AW-1:0];
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #12;
    exp(0); chk("rst_stall", 32'(stall_o));
    exp(0); chk("rst_busy", 32'(var_busy_o));
    exp(0); chk("rst_err", 32'(err_o));
    exp(0); chk("rst_pend", pending_o);
    rst_n = 1;
    tick();

    // lat=1 to x5, consumer next cycle
    iss(5, 1); #1;
    exp(0); chk("x5_issue_stall", 32'(stall_o));
    tick(); idle(); use_src(0, 5); #1;
    exp(1); chk("x5_pend", 32'(pending_o[5]));
    exp(0); chk("x5_use_stall", 32'(stall_o));
    exp(1); chk("x5_sel0", 32'(sel(0)));
    tick(); idle(); #1;
    exp(0); chk("x5_freed", 32'(pending_o[5]));

    // lat=4 to x7: two stall cycles then bypass at 2
    iss(7, 4); tick(); idle(); use_src(0, 7); #1;
    exp(1); chk("x7_stall_a", 32'(stall_o));
    tick();
    exp(1); chk("x7_stall_b", 32'(stall_o));
    tick();
    exp(0); chk("x7_go", 32'(stall_o));
    exp(2); chk("x7_sel0", 32'(sel(0)));
    tick(); idle(); tick(); tick();
    exp(0); chk("x7_freed", 32'(pending_o[7]));

    // variable op to x9, consumer on rs3
    iss(9, 0); #1;
    exp(0); chk("x9_issue_stall", 32'(stall_o));
    tick(); idle(); #1;
    exp(1); chk("x9_busy1", 32'(var_busy_o));
    use_src(2, 9); #1;
    exp(1); chk("x9_stall_a", 32'(stall_o));
    tick();
    exp(1); chk("x9_stall_b", 32'(stall_o));
    cpl(9); #1;
    exp(0); chk("x9_cpl_stall", 32'(stall_o));
    exp(7); chk("x9_sel2", 32'(sel(2)));
    tick(); idle(); #1;
    exp(0); chk("x9_busy0", 32'(var_busy_o));
    exp(0); chk("x9_pend", 32'(pending_o[9]));
    exp(0); chk("x9_err", 32'(err_o));

    // var_full with x1,x2 outstanding; stray completion to x3
    iss(1, 0); tick(); iss(2, 0); tick(); idle(); #1;
    exp(2); chk("vf_busy2", 32'(var_busy_o));
    iss(3, 0); #1;
    exp(1); chk("vf_stall_a", 32'(stall_o));
    cpl(3); tick(); cpl_valid_i = 0; #1;
    exp(1); chk("vf_err", 32'(err_o));
    exp(1); chk("vf_stall_b", 32'(stall_o));
    exp(0); chk("vf_x3_pend", 32'(pending_o[3]));
    cpl(1); #1;
    exp(1); chk("vf_stall_cpl", 32'(stall_o));
    tick(); cpl_valid_i = 0; #1;
    exp(0); chk("vf_go", 32'(stall_o));
    tick(); idle(); #1;
    exp(2); chk("vf_busy_x3", 32'(var_busy_o));
    exp(1); chk("vf_x3_var", 32'(pending_o[3]));
    cpl(2); tick(); cpl(3); tick(); idle(); #1;
    exp(0); chk("vf_drained", 32'(var_busy_o));
    exp(1); chk("vf_err_sticky", 32'(err_o));

    // WAW: lat=3 then lat=1 to x4
    iss(4, 3); tick(); iss(4, 1); #1;
    exp(1); chk("waw_a", 32'(stall_o));
    tick();
    exp(1); chk("waw_b", 32'(stall_o));
    tick();
    exp(0); chk("waw_go", 32'(stall_o));
    tick(); idle(); #1;
    exp(1); chk("waw_realloc", 32'(pending_o[4]));
    tick();
    exp(0); chk("waw_freed", 32'(pending_o[4]));

    // x0 never pending
    iss(0, 2); tick(); idle(); #1;
    exp(0); chk("x0_pend", 32'(pending_o[0]));

    // flush suppresses allocation
    iss(6, 2); flush_i = 1; tick(); idle(); #1;
    exp(0); chk("flush_x6", 32'(pending_o[6]));

    // reset drops two outstanding var ops
    iss(10, 0); tick(); iss(11, 0); tick(); idle(); #1;
    exp(2); chk("pre_rst_busy", 32'(var_busy_o));
    rst_n = 0; #1;
    exp(0); chk("mid_rst_busy", 32'(var_busy_o));
    exp(0); chk("mid_rst_pend", pending_o);
    exp(0); chk("mid_rst_err", 32'(err_o));
    exp(0); chk("mid_rst_stall", 32'(stall_o));
    #6; rst_n = 1;
    tick();

    // illegal latency: error, tracked as variable
    iss(13, 7); tick(); idle(); #1;
    exp(1); chk("lat7_err", 32'(err_o));
    exp(1); chk("lat7_busy", 32'(var_busy_o));
    exp(1); chk("lat7_pend", 32'(pending_o[13]));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
Parametrised register scoreboard and hazard unit for the decode stage. It generalises fixed E/M/W forwarding and load-use stalling to any number of source operands, per-instruction result latencies, and variable-latency units (divider, FP) that complete out of band. It tracks pending destination writes per architectural register and drives the decode stall and per-source bypass selects. It sits beside the control unit and register file in the decode stage.

Parameters:
REG_ADDR_WIDTH, 5, register address width; 2**REG_ADDR_WIDTH tracked registers
NUM_SRC, 3, number of source operand ports (rs1, rs2, rs3 for FMA)
LAT_WIDTH, 3, width of latency counters and bypass selects; maximum fixed latency is 2**LAT_WIDTH-2
FWD_DEPTH, 2, a fixed-latency result with remaining count <= FWD_DEPTH is bypassable
MAX_VAR, 2, maximum outstanding variable-latency writes
ZERO_HARDWIRED, 1, when 1, register 0 is never marked pending

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
issue_valid_i  in  1  decoded instruction present
issue_wr_i  in  1  instruction writes rd
issue_rd_i  in  REG_ADDR_WIDTH  destination register
issue_lat_i  in  LAT_WIDTH  0 = variable latency; 1..2**LAT_WIDTH-2 = fixed cycles to result
src_used_i  in  NUM_SRC  per-source used flag
src_addr_i  in  NUM_SRC*REG_ADDR_WIDTH  source addresses; source i at [i*W +: W]
flush_i  in  1  kill the current decode slot
cpl_valid_i  in  1  variable-latency result written this cycle
cpl_rd_i  in  REG_ADDR_WIDTH  completing register
stall_o  out  1  hold decode
fwd_sel_o  out  NUM_SRC*LAT_WIDTH  per-source bypass select
var_busy_o  out  clog2(MAX_VAR+1)  outstanding variable-latency count
pending_o  out  2**REG_ADDR_WIDTH  per-register pending vector (debug)
err_o  out  1  sticky protocol error

Behaviour:
- Reset is asynchronous, active-low, on clk and rst_n. During reset all pending, var and cnt state clears, var_busy_o=0 and err_o=0. stall_o and fwd_sel_o are then 0, since nothing is pending. Reset mid-operation drops all tracking.
- Per-register state: pending[r], var[r], cnt[r] (LAT_WIDTH bits).
- Accept condition: accept = issue_valid_i & ~stall_o & ~flush_i.
- Allocation: on accept with issue_wr_i, when rd!=0 or ZERO_HARDWIRED==0:
  - pending[rd] <= 1.
  - If issue_lat_i==0: var[rd] <= 1 and var_busy increments.
  - Otherwise: var[rd] <= 0 and cnt[rd] <= issue_lat_i.
- Fixed-latency countdown: every cycle, each pending non-var register decrements cnt. When cnt==1 it clears pending and cnt reaches 0. A result issued with lat=L therefore frees the register exactly L cycles after accept.
- Variable-latency completion: cpl_valid_i & pending[cpl_rd_i] & var[cpl_rd_i] clears pending and var at the next edge and decrements var_busy.
  - cpl_valid_i to a register that is not pending, or pending but not var, sets err_o and is otherwise ignored.
  - If allocate and completion hit var_busy in the same cycle, the net change is 0.
- Source readiness (combinational): source i is not ready when src_used_i[i] & pending[a] and either:
  - var[a] and no completion to a this cycle, or
  - ~var[a] and cnt[a] > FWD_DEPTH.
  Register 0 is always ready when ZERO_HARDWIRED=1.
- fwd_sel_o per source:
  - 0 = register file (not pending or not used).
  - cnt[a] = bypass from the stage that many cycles from result.
  - all-ones = completion bypass, when cpl_valid_i & cpl_rd_i==a & var[a].
  - When the source is not ready the value is don't-care.
- stall_o = issue_valid_i & (any source not ready | WAW | var_full).
  - WAW: issue_wr_i & pending[rd] & (var[rd] | issue_lat_i==0 | cnt[rd] > issue_lat_i). This forbids out-of-order writes to one register.
  - var_full: issue_wr_i & issue_lat_i==0 & var_busy_o==MAX_VAR.
- flush_i suppresses allocation only. State of already-accepted instructions is untouched. stall_o still evaluates and is ignored upstream.
- Simultaneous allocate and countdown/clear on the same register: allocation wins. It is reachable only when the old entry clears this cycle, since WAW otherwise stalls.
- Accepting issue_lat_i == 2**LAT_WIDTH-1 sets err_o; the allocation is treated as variable.

Test Plan:
- Reset, then issue lat=1 to x5 and next cycle use x5 as rs1 -> stall_o=0, fwd_sel src0=1, pending_o[5] cleared after 1 cycle.
- Issue lat=4 (load-like, FWD_DEPTH=2) to x7, then immediately use x7 -> stall_o=1 for 2 cycles, then 0 with fwd_sel=2.
- Issue variable op to x9, then use x9 as rs3 -> stall until cpl_valid_i with cpl_rd_i=9. That cycle stall_o=0 and fwd_sel src2=7 (all-ones); var_busy_o goes 1 -> 0.
- Two variable ops (x1, x2) outstanding, issue a third variable op -> stall_o=1 (var_full) until one completes. A stray cpl_rd_i=3 sets err_o=1 and it stays set.
- Issue lat=3 to x4, then lat=1 to x4 -> WAW stall for 2 cycles. Issue to x0 with ZERO_HARDWIRED=1 -> pending_o[0] stays 0.
- Assert flush_i with issue_valid_i to x6 -> pending_o[6] stays 0. Assert rst_n=0 with 2 var ops pending -> all outputs 0 immediately.
